fb_ifetch: RTL and testbench

- Instruction fetch buffer between fb_pc and the decode stage.
- Consumes the PC's current word address, issues reads to a synchronous word-addressed instruction ROM, and queues returned instructions with their PCs in a small FIFO.
- Presents the queued instructions to decode with a valid/ready handshake.
- Generates the PC hold signal (fb_pc pc_write semantics: 1 = hold) and handles pipeline flushes on redirect.

---
 rtl/fb_ifetch.sv | 126 ++++++++++++
 tb/tb_fb_ifetch.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fb_ifetch.sv
// fb_ifetch: instruction fetch buffer between fb_pc and decode.
// Issues synchronous ROM reads from the PC, queues {pc, inst} in a FIFO and
// hands them to decode over valid/ready. Drives the PC hold and handles flushes.
// Optional macro FB_IF_BYPASS_EN: forward ROM data straight to decode when
// the FIFO is empty (latency T+1 instead of T+2).
// Ports:
//   clk, if_reset            clock, synchronous active-high reset
//   pc_address / pc_hold     current PC word address / hold request to fb_pc
//   if_flush                 redirect flush
//   rom_en/rom_addr/rom_data synchronous ROM read port (data one cycle later)
//   dec_valid/dec_ready      decode handshake; dec_inst/dec_pc payload
//   if_count                 FIFO occupancy
module fb_ifetch #(
    parameter int DEPTH  = 4,
    parameter int ROM_AW = 10
) (
    input  logic                    clk,
    input  logic                    if_reset,
    input  logic [31:0]             pc_address,
    output logic                    pc_hold,
    input  logic                    if_flush,
    output logic                    rom_en,
    output logic [ROM_AW-1:0]       rom_addr,
    input  logic [31:0]             rom_data,
    output logic                    dec_valid,
    input  logic                    dec_ready,
    output logic [31:0]             dec_inst,
    output logic [31:0]             dec_pc,
    output logic [$clog2(DEPTH):0]  if_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

    logic [31:0]   r_mem_inst [DEPTH];
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [31:0]   r_cap_pc;

    logic [CW:0]   w_credit;
    logic          w_kill;
    logic          w_issue;
    logic          w_fifo_valid;
    logic          w_byp_valid;
    logic          w_byp_take;
    logic          w_push;
    logic          w_pop;

    assign w_kill = if_reset | if_flush;

    // A slot is reserved for the outstanding read, so a push never hits a full FIFO.
    assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_issue  = !w_kill && (w_credit < LP_DEPTH);

    assign rom_en   = w_issue;
    assign rom_addr = pc_address[ROM_AW-1:0];
    // During a flush the PC must be free to load its redirect target;
    // reset overrides that and holds the PC.
    assign pc_hold  = if_reset | (!w_issue && !if_flush);

    assign w_fifo_valid = !w_kill && (r_count != '0);

`ifdef FB_IF_BYPASS_EN
    assign w_byp_valid = !w_kill && r_inflight && (r_count == '0);
`else
    assign w_byp_valid = 1'b0;
`endif

    assign w_byp_take = w_byp_valid & dec_ready;
    assign w_push     = !w_kill && r_inflight && !w_byp_take;
    assign w_pop      = w_fifo_valid && dec_ready;

    assign dec_valid = w_fifo_valid | w_byp_valid;
    assign if_count  = r_count;

    always_comb begin
        dec_inst = 32'h0;
        dec_pc   = 32'h0;
        if (w_fifo_valid) begin
            dec_inst = r_mem_inst[r_rptr];
            dec_pc   = r_mem_pc[r_rptr];
        end else if (w_byp_valid) begin
            dec_inst = rom_data;
            dec_pc   = r_cap_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_inflight <= 1'b0;
            r_cap_pc   <= 32'h0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_cap_pc <= pc_address;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_inst[r_wptr] <= rom_data;
            r_mem_pc[r_wptr]   <= r_cap_pc;
        end
    end

endmodule

// File: tb/tb_fb_ifetch.sv
// tb_fb_ifetch: directed self-checking bench for fb_ifetch.
// Models fb_pc and a ROM holding 32'h100 + address.
module tb_fb_ifetch;

    localparam int DEPTH  = 4;
    localparam int ROM_AW = 10;
`ifdef FB_IF_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam logic BYP = (LAT == 1);

    logic              clk = 1'b0;
    logic              if_reset = 1'b1;
    logic              if_flush = 1'b0;
    logic              dec_ready = 1'b0;
    logic [31:0]       pc_address = 32'h0;
    logic [31:0]       rom_data = 32'hFFFF_FFFF;
    logic [31:0]       redirect = 32'h0;
    logic              pc_hold;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic              dec_valid;
    logic [31:0]       dec_inst;
    logic [31:0]       dec_pc;
    logic [2:0]        if_count;

    int n_cmp = 0;
    int n_fail = 0;

    fb_ifetch #(.DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
        .clk(clk), .if_reset(if_reset), .pc_address(pc_address),
        .pc_hold(pc_hold), .if_flush(if_flush), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .if_count(if_count)
    );

    always #5 clk = ~clk;

    // fb_pc model: reset to 0, load redirect on flush, advance when not held.
    always @(posedge clk) begin
        if (if_reset) pc_address <= 32'h0;
        else if (if_flush) pc_address <= redirect;
        else if (!pc_hold) pc_address <= pc_address + 32'd1;
    end

    // Synchronous ROM; garbage on cycles with no read.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 32'h100 + {22'h0, rom_addr};
        else rom_data <= 32'hFFFF_FFFF;
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        if_reset = 1'b1; if_flush = 1'b0; dec_ready = rdy;
        repeat (2) @(posedge clk);
        #1 if_reset = 1'b0;
    endtask

    task automatic test_reset();
        dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        n_cmp++; if (dec_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", dec_inst); end
        n_cmp++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", dec_pc); end
        n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL reset_rom_en: got %b want 0", rom_en); end
        n_cmp++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", pc_hold); end
        n_cmp++; if (if_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", if_count); end
        @(posedge clk); #1 if_reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL release_rom_en: got %b want 1", rom_en); end
        n_cmp++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL release_addr: got %h want 0", rom_addr); end
        n_cmp++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL release_hold: got %b want 0", pc_hold); end
    endtask

    task automatic test_stream();
        int idx;
        int first;
        idx = 0; first = -1;
        do_reset(1'b1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL stream_hold: cyc %0d got %b want 0", c, pc_hold); end
            if (dec_valid === 1'b1) begin
                if (first < 0) first = c;
                n_cmp++; if (dec_inst !== 32'h100 + idx) begin n_fail++; $display("FAIL stream_inst: got %h want %h", dec_inst, 32'h100 + idx); end
                n_cmp++; if (dec_pc !== idx) begin n_fail++; $display("FAIL stream_pc: got %h want %h", dec_pc, idx); end
                idx++;
            end
        end
        n_cmp++; if (first !== LAT) begin n_fail++; $display("FAIL stream_latency: got %0d want %0d", first, LAT); end
        n_cmp++; if (idx !== 20 - LAT) begin n_fail++; $display("FAIL stream_count: got %0d want %0d", idx, 20 - LAT); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (if_count !== 3'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", if_count); end
        n_cmp++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b want 1", pc_hold); end
        n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL bp_rom_en: got %b want 0", rom_en); end
        n_cmp++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b want 1", dec_valid); end
        n_cmp++; if (dec_inst !== 32'h100) begin n_fail++; $display("FAIL bp_head: got %h want 100", dec_inst); end
        @(posedge clk); #1 dec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL bp_drain_valid: cyc %0d got %b want 1", c, dec_valid); end
            n_cmp++; if (dec_inst !== 32'h100 + c) begin n_fail++; $display("FAIL bp_drain_inst: got %h want %h", dec_inst, 32'h100 + c); end
            n_cmp++; if (dec_pc !== c) begin n_fail++; $display("FAIL bp_drain_pc: got %h want %h", dec_pc, c); end
            n_cmp++; if (if_count > 3'd4) begin n_fail++; $display("FAIL bp_overflow: got %0d want <=4", if_count); end
        end
    endtask

    task automatic test_flush();
        int got;
        got = 0;
        do_reset(1'b0);
        repeat (4) @(posedge clk);
        #1 if_flush = 1'b1; redirect = 32'h40;
        @(negedge clk);
        n_cmp++; if (if_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", if_count); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", dec_valid); end
        n_cmp++; if (dec_inst !== 32'h0) begin n_fail++; $display("FAIL flush_inst: got %h want 0", dec_inst); end
        n_cmp++; if (pc_hold !== 1'b0) begin n_fail++; $display("FAIL flush_hold: got %b want 0", pc_hold); end
        n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL flush_rom_en: got %b want 0", rom_en); end
        @(posedge clk); #1 if_flush = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (if_count !== 3'd0) begin n_fail++; $display("FAIL flush_post_count: got %0d want 0", if_count); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL flush_post_valid: got %b want 0", dec_valid); end
        n_cmp++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL flush_reissue: got %b want 1", rom_en); end
        n_cmp++; if (rom_addr !== 10'h40) begin n_fail++; $display("FAIL flush_addr: got %h want 40", rom_addr); end
        for (int c = 0; c < 6 && got < 2; c++) begin
            @(negedge clk);
            if (dec_valid === 1'b1) begin
                n_cmp++; if (dec_pc !== 32'h40 + got) begin n_fail++; $display("FAIL flush_pc: got %h want %h", dec_pc, 32'h40 + got); end
                n_cmp++; if (dec_inst !== 32'h140 + got) begin n_fail++; $display("FAIL flush_inst_out: got %h want %h", dec_inst, 32'h140 + got); end
                got++;
            end
        end
        n_cmp++; if (got !== 2) begin n_fail++; $display("FAIL flush_timeout: got %0d words want 2", got); end
    endtask

    task automatic test_bypass();
        do_reset(1'b1);
        @(negedge clk);
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL byp_c0_valid: got %b want 0", dec_valid); end
        n_cmp++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL byp_c0_rom_en: got %b want 1", rom_en); end
        @(negedge clk);
        n_cmp++; if (dec_valid !== BYP) begin n_fail++; $display("FAIL byp_c1_valid: got %b want %b", dec_valid, BYP); end
        n_cmp++; if (dec_inst !== (BYP ? 32'h100 : 32'h0)) begin n_fail++; $display("FAIL byp_c1_inst: got %h", dec_inst); end
        n_cmp++; if (if_count !== 3'd0) begin n_fail++; $display("FAIL byp_c1_count: got %0d want 0", if_count); end
        @(negedge clk);
        n_cmp++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL byp_c2_valid: got %b want 1", dec_valid); end
        n_cmp++; if (dec_inst !== (BYP ? 32'h101 : 32'h100)) begin n_fail++; $display("FAIL byp_c2_inst: got %h", dec_inst); end
        n_cmp++; if (if_count !== (BYP ? 3'd0 : 3'd1)) begin n_fail++; $display("FAIL byp_c2_count: got %0d", if_count); end
    endtask

    task automatic test_reset_flush();
        int got;
        got = 0;
        do_reset(1'b0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (if_count !== 3'd4) begin n_fail++; $display("FAIL rf_full: got %0d want 4", if_count); end
        @(posedge clk); #1 if_reset = 1'b1; if_flush = 1'b1; redirect = 32'h40;
        @(negedge clk);
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rf_valid: got %b want 0", dec_valid); end
        n_cmp++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL rf_rom_en: got %b want 0", rom_en); end
        n_cmp++; if (pc_hold !== 1'b1) begin n_fail++; $display("FAIL rf_hold: got %b want 1", pc_hold); end
        @(negedge clk);
        n_cmp++; if (if_count !== 3'd0) begin n_fail++; $display("FAIL rf_count: got %0d want 0", if_count); end
        @(posedge clk); #1 if_reset = 1'b0; if_flush = 1'b0; dec_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL rf_issue: got %b want 1", rom_en); end
        n_cmp++; if (rom_addr !== 10'd0) begin n_fail++; $display("FAIL rf_addr: got %h want 0", rom_addr); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL rf_post_valid: got %b want 0", dec_valid); end
        for (int c = 0; c < 6 && got < 1; c++) begin
            @(negedge clk);
            if (dec_valid === 1'b1) begin
                n_cmp++; if (dec_pc !== 32'h0) begin n_fail++; $display("FAIL rf_first_pc: got %h want 0", dec_pc); end
                n_cmp++; if (dec_inst !== 32'h100) begin n_fail++; $display("FAIL rf_first_inst: got %h want 100", dec_inst); end
                got++;
            end
        end
        n_cmp++; if (got !== 1) begin n_fail++; $display("FAIL rf_timeout: got %0d words want 1", got); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_bypass();
        test_reset_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
